// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULU/DIVU sequencer that borrows the core's 32-bit ALU
// for one add/subtract per step, XLEN steps per operation.
module alu_muldiv_seq #(
  parameter int         XLEN    = 32,
  parameter logic [3:0] SEL_ADD = 4'b0010,
  parameter logic [3:0] SEL_SUB = 4'b0110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res_lo,
  output logic [XLEN-1:0] res_hi,
  output logic            div_by_zero,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] alu_res
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic            op_r;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] hi, lo;
  logic [CW-1:0]   cnt;

  logic            top, carry, borrow, ok, last;
  logic [XLEN-1:0] shr, hi_nx, lo_nx;

  assign last = (cnt == CW'(XLEN - 1));

  always_comb begin
    top     = hi[XLEN-1];
    shr     = {hi[XLEN-2:0], lo[XLEN-1]};
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = SEL_ADD;
    if (state == RUN) begin
      if (!op_r) begin
        alu_a = hi;
        alu_b = lo[0] ? divisor : '0;
      end else begin
        alu_a   = shr;
        alu_b   = divisor;
        alu_sel = SEL_SUB;
      end
    end
    // Carry/borrow reconstructed from operand and result MSBs; the ALU has no flag outputs.
    carry  = (alu_a[XLEN-1] & alu_b[XLEN-1]) |
             ((alu_a[XLEN-1] | alu_b[XLEN-1]) & ~alu_res[XLEN-1]);
    borrow = (~alu_a[XLEN-1] & alu_b[XLEN-1]) |
             (~(alu_a[XLEN-1] ^ alu_b[XLEN-1]) & alu_res[XLEN-1]);
    ok     = top | ~borrow;
    if (!op_r) begin
      hi_nx = {carry, alu_res[XLEN-1:1]};
      lo_nx = {alu_res[0], lo[XLEN-1:1]};
    end else begin
      hi_nx = ok ? alu_res : shr;
      lo_nx = {lo[XLEN-2:0], ok};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_r        <= 1'b0;
      divisor     <= '0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      res_lo      <= '0;
      res_hi      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r    <= op;
            divisor <= opb;
            busy    <= 1'b1;
            hi      <= '0;
            lo      <= opa;
            cnt     <= '0;
            if (op && (opb == '0)) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              res_lo      <= '1;
              res_hi      <= opa;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt + 1'b1;
          // Publish the final step's next values so results line up with done.
          if (last) begin
            state       <= DONE;
            done        <= 1'b1;
            div_by_zero <= 1'b0;
            res_lo      <= lo_nx;
            res_hi      <= hi_nx;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ALU on the shared-ALU port.
module tb_alu_muldiv_seq;

  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        rst_n, start, op;
  logic [31:0] opa, opb;
  logic        busy, done, div_by_zero;
  logic [31:0] res_lo, res_hi, alu_a, alu_b, alu_res;
  logic [3:0]  alu_sel;

  int n_pass = 0;
  int n_total = 0;

  alu_muldiv_seq #(.XLEN(32), .SEL_ADD(SEL_ADD), .SEL_SUB(SEL_SUB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi),
    .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_res(alu_res)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_res = '0;
    if (alu_sel == SEL_ADD)      alu_res = alu_a + alu_b;
    else if (alu_sel == SEL_SUB) alu_res = alu_a - alu_b;
  end

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] a, b, lo, hi;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Caller is positioned at a negedge in an IDLE cycle; returns at the negedge of
  // the IDLE cycle after done, so consecutive calls exercise back-to-back starts.
  task automatic run_op(input vec_t v, input int inj);
    int lat;
    int sel_bad;
    logic b1;
    logic [3:0] want_sel;
    want_sel = v.op ? SEL_SUB : SEL_ADD;
    start = 1'b1; op = v.op; opa = v.a; opb = v.b;
    @(negedge clk);
    start = 1'b0; op = 1'b0; opa = $urandom; opb = $urandom;
    lat = 1; sel_bad = 0; b1 = busy;
    while (!done && lat < 40) begin
      if (alu_sel !== want_sel) sel_bad++;
      if (lat == inj) begin
        start = 1'b1; op = 1'b1; opa = 32'd100; opb = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({v.name, " busy"},    64'(b1),          64'd1);
    chk({v.name, " latency"}, 64'(lat),         64'(v.lat));
    chk({v.name, " res_lo"},  64'(res_lo),      64'(v.lo));
    chk({v.name, " res_hi"},  64'(res_hi),      64'(v.hi));
    chk({v.name, " dbz"},     64'(div_by_zero), 64'(v.dbz));
    if (v.lat > 1) chk({v.name, " alu_sel"}, 64'(sel_bad), 64'd0);
    @(negedge clk);
    chk({v.name, " done pulse"}, 64'(done), 64'd0);
    chk({v.name, " busy drop"},  64'(busy), 64'd0);
    chk({v.name, " res hold"},   {res_hi, res_lo}, {v.hi, v.lo});
  endtask

  initial begin
    int dones;
    vecs[0] = '{"mul7x6",   1'b0, 32'd7,        32'd6,        32'd42,       32'd0,        1'b0, 33};
    vecs[1] = '{"mulmax",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
    vecs[2] = '{"mul2^32",  1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 33};
    vecs[3] = '{"div100/7", 1'b1, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
    vecs[4] = '{"divtop",   1'b1, 32'hFFFFFFFF, 32'h80000001, 32'd1,        32'h7FFFFFFE, 1'b0, 33};
    vecs[5] = '{"divzero",  1'b1, 32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, 1};
    vecs[6] = '{"divby1",   1'b1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 33};
    vecs[7] = '{"div5/9",   1'b1, 32'd5,        32'd9,        32'd0,        32'd5,        1'b0, 33};
    vecs[8] = '{"mulzero",  1'b0, 32'd0,        32'h12345678, 32'd0,        32'd0,        1'b0, 33};

    rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    chk("rst busy",    64'(busy), 64'd0);
    chk("rst done",    64'(done), 64'd0);
    chk("rst dbz",     64'(div_by_zero), 64'd0);
    chk("rst res",     {res_hi, res_lo}, 64'd0);
    chk("rst alu_sel", 64'(alu_sel), 64'(SEL_ADD));
    chk("rst alu_ab",  {alu_a, alu_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i], -1);

    // start during RUN must be dropped; the next call then starts right after IDLE.
    run_op(vecs[0], 10);
    run_op(vecs[3], -1);

    // Reset mid-run clears everything and no done follows.
    start = 1'b1; op = 1'b0; opa = 32'd9; opb = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst res",  {res_hi, res_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst no done", 64'(dones), 64'd0);
    chk("midrst idle",    64'(busy), 64'd0);
    run_op(vecs[1], -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer that time-shares the core's combinational 32-bit ALU.
- Drives the ALU operands and select code.
- Iterates shift-add (MULU) or restoring shift-subtract (DIVU) for XLEN steps.
- Returns the result through a start/done handshake to the execute stage.

Parameters:
XLEN, 32, operand width; iteration count = XLEN
SEL_ADD, 4'b0010, ALU select code for add
SEL_SUB, 4'b0110, ALU select code for subtract

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = MULU, 1 = DIVU; sampled with start
opa  input  XLEN  multiplicand / dividend; sampled with start
opb  input  XLEN  multiplier / divisor; sampled with start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; result valid
res_lo  output  XLEN  MULU product[XLEN-1:0] / DIVU quotient
res_hi  output  XLEN  MULU product[2*XLEN-1:XLEN] / DIVU remainder
div_by_zero  output  1  valid with done; DIVU with opb == 0
alu_a  output  XLEN  ALU operand a
alu_b  output  XLEN  ALU operand b
alu_sel  output  4  ALU select
alu_res  input  XLEN  ALU result (combinational, same cycle)

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - busy, done and div_by_zero are 0.
  - res_lo and res_hi are 0.
  - Counter and internal registers are cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States are IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start = 1 latches op, opa, opb and moves to RUN with count = 0.
  - Exception: DIVU with opb == 0 goes directly to DONE.
  - alu_a = 0, alu_b = 0, alu_sel = SEL_ADD.
- RUN, MULU (acc = hi register, mq = lo register, loaded acc = 0, mq = opa):
  - alu_a = acc, alu_b = mq[0] ? opb : 0, alu_sel = SEL_ADD.
  - carry = (a[MSB]&b[MSB]) | ((a[MSB]|b[MSB]) & ~alu_res[MSB]).
  - {acc, mq} <= {carry, alu_res, mq[XLEN-1:1]}.
- RUN, DIVU (rem = hi, quo = lo, loaded rem = 0, quo = opa):
  - Form the shifted remainder {top, r} = {rem, quo[MSB]}; top is the bit shifted out.
  - alu_a = r, alu_b = opb, alu_sel = SEL_SUB.
  - borrow = (~a[MSB]&b[MSB]) | (~(a[MSB]^b[MSB]) & alu_res[MSB]).
  - ok = top | ~borrow.
  - rem <= ok ? alu_res : r.
  - quo <= {quo[XLEN-2:0], ok}.
- Counter increments every RUN cycle. RUN lasts exactly XLEN cycles, then moves to DONE.
- DONE: done = 1 for one cycle; res_lo and res_hi are updated from the registers the same cycle; next state is IDLE.
- Latency:
  - Start accepted at edge N. busy is high from N+1 through the DONE cycle.
  - done is high in cycle N+1+XLEN (33 clocks after start for XLEN = 32).
  - Divide by zero: done in cycle N+1.
- Divide by zero: res_lo = all ones, res_hi = opa, div_by_zero = 1.
- div_by_zero is 0 for every other completion; it holds until the next done.
- res_lo and res_hi hold their value until the next done; they are not cleared by a new start.
- start while busy = 1 (RUN or DONE) is ignored and not queued.
- start in the IDLE cycle immediately after DONE is accepted (back-to-back operation).
- Operand inputs are don't-care except in the cycle start is accepted.
- alu_a, alu_b and alu_sel are combinational from state and registers. Sharing them with the execute path is resolved by busy at the mux outside this block.

Test Plan:
- MULU opa = 7, opb = 6 -> done exactly 33 cycles after start; res_lo = 42, res_hi = 0; alu_sel = 4'b0010 throughout RUN.
- MULU opa = 0xFFFFFFFF, opb = 0xFFFFFFFF -> res_hi = 0xFFFFFFFE, res_lo = 0x00000001 (checks the carry path).
- DIVU opa = 100, opb = 7 -> res_lo = 14, res_hi = 2, div_by_zero = 0. Then DIVU opa = 0xFFFFFFFF, opb = 0x80000001 -> res_lo = 1, res_hi = 0x7FFFFFFE (checks the top bit and borrow path).
- DIVU opb = 0, opa = 0x1234 -> done on the cycle after start; res_lo = 0xFFFFFFFF, res_hi = 0x1234, div_by_zero = 1.
- start pulsed at RUN cycle 10 with different operands -> ignored; the original result is returned. start in the IDLE cycle right after done -> accepted; second done 33 cycles later.
- rst_n low at RUN cycle 15 -> busy, done and res_* go to 0 immediately. No done pulse follows. A new start after reset release completes normally.
